// File: rtl/req_ack_2ph_rx.sv
// Receive side of a two-phase req/ack crossing: synchronizes req toggles, captures din, acks, and buffers words onto a val/rdy stream.
// Optional even-parity check on the captured word is enabled by defining REQ_ACK_RX_PARITY_EN.
module req_ack_2ph_rx #(
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                              clk_tx,
    input  logic                              rst_b,
    input  logic                              req,
    input  logic [DW-1:0]                     din,
`ifdef REQ_ACK_RX_PARITY_EN
    input  logic                              din_par,
    output logic                              par_err,
`endif
    output logic                              ack,
    output logic                              val,
    output logic [DW-1:0]                     dout,
    input  logic                              rdy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   lvl,
    output logic                              proto_err
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   req_edge;
    logic [DW-1:0]          hold_q;
    logic                   ack_q;
    logic                   capture, push, pop, err_edge;

    logic [DW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wptr_q, rptr_q;
    logic [LW-1:0]          count_q;
    logic [DW-1:0]          last_q;
    logic                   proto_q;

    // Bit 0 of the chain is the only flop that may go metastable.
    // NOTE: all state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign req_edge = sync_q[SYNC_STAGES-1] ^ hist_q;

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Push decision uses the registered count, so a pop never frees a slot for the same edge.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d  = state_q;
        capture  = 1'b0;
        push     = 1'b0;
        err_edge = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_edge) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                err_edge = req_edge;
                if (count_q < DEPTH_L) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign val = (count_q != '0);
    assign pop = val && rdy;

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b) begin
            hold_q  <= '0;
            ack_q   <= 1'b0;
            proto_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            if (capture)  hold_q  <= din;
            if (push)     ack_q   <= ~ack_q;
            if (err_edge) proto_q <= 1'b1;
            if (push)     wptr_q  <= wptr_q + PW'(1);
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
                last_q <= mem[rptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the empty count guarantees stale entries are never presented.
    always_ff @(posedge clk_tx) begin
        if (push) mem[wptr_q] <= hold_q;
    end

`ifdef REQ_ACK_RX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_tx or negedge rst_b) begin
        if (!rst_b)                          par_q <= 1'b0;
        else if (capture && (^din != din_par)) par_q <= 1'b1;
    end

    assign par_err = par_q;
`endif

    // When empty, dout keeps showing the last word handed downstream.
    assign dout      = val ? mem[rptr_q] : last_q;
    assign ack       = ack_q;
    assign lvl       = count_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_req_ack_2ph_rx.sv
// Scoreboard bench for req_ack_2ph_rx: words are queued when sent and checked in order as the stream delivers them.
// Parity checks are included when REQ_ACK_RX_PARITY_EN is defined.
module tb_req_ack_2ph_rx;

    localparam int DW          = 16;
    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 2;
    localparam int LW          = $clog2(FIFO_DEPTH + 1);

    logic          clk_tx = 1'b0;
    logic          rst_b;
    logic          req;
    logic [DW-1:0] din;
    logic          ack;
    logic          val;
    logic [DW-1:0] dout;
    logic          rdy;
    logic [LW-1:0] lvl;
    logic          proto_err;
`ifdef REQ_ACK_RX_PARITY_EN
    logic          din_par;
    logic          par_err;
`endif

    int            tests = 0;
    int            fails = 0;
    int            val_cycles = 0;
    int            pops = 0;
    logic          exp_ack;
    logic [DW-1:0] sb [$];

    req_ack_2ph_rx #(
        .DW(DW), .SYNC_STAGES(SYNC_STAGES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_tx    (clk_tx),
        .rst_b     (rst_b),
        .req       (req),
        .din       (din),
`ifdef REQ_ACK_RX_PARITY_EN
        .din_par   (din_par),
        .par_err   (par_err),
`endif
        .ack       (ack),
        .val       (val),
        .dout      (dout),
        .rdy       (rdy),
        .lvl       (lvl),
        .proto_err (proto_err)
    );

    always #5 clk_tx = ~clk_tx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stream monitor: outputs are stable at the falling edge; a handshake there completes on the next rise.
    always @(negedge clk_tx) begin
        if (rst_b && val) begin
            val_cycles++;
            if (rdy) begin
                pops++;
                if (sb.size() == 0) check("sb_underflow", 32'd0, 32'd1);
                else                check("dout_order", 32'(dout), 32'(sb.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_tx);
            #2;
        end
    endtask

    task automatic send(input logic [DW-1:0] w, input logic bad_par = 1'b0);
        din = w;
`ifdef REQ_ACK_RX_PARITY_EN
        din_par = (^w) ^ bad_par;
`else
        if (bad_par) din = w;
`endif
        sb.push_back(w);
        req = ~req;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        exp_ack = ~exp_ack;
        while (ack !== exp_ack && n < budget) begin
            @(posedge clk_tx);
            #2;
            n++;
        end
        check(tag, 32'(ack), 32'(exp_ack));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || lvl != '0) && n < 20) begin
            @(posedge clk_tx);
            #2;
            n++;
        end
        check(tag, 32'(lvl), 32'd0);
        check({tag, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int v0, p0, got;
        rst_b   = 1'b0;
        req     = 1'b0;
        din     = '0;
        rdy     = 1'b0;
        exp_ack = 1'b0;
`ifdef REQ_ACK_RX_PARITY_EN
        din_par = 1'b0;
`endif
        cyc(3);
        rst_b = 1'b1;
        cyc(20);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_val", 32'(val), 32'd0);
        check("rst_lvl", 32'(lvl), 32'd0);
        check("rst_proto", 32'(proto_err), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);

        // Single word, free-flowing stream.
        rdy = 1'b1;
        v0  = val_cycles;
        send(16'hA5C3);
        wait_ack("ack_single", SYNC_STAGES + 3);
        wait_drain("drain_single");
        cyc(3);
        check("val_one_cycle", 32'(val_cycles - v0), 32'd1);
        check("dout_hold", 32'(dout), 32'h0000_A5C3);
        check("val_idle", 32'(val), 32'd0);

        // Backpressure: two words fill the buffer, the third is withheld.
        rdy = 1'b0;
        send(16'h0001);
        wait_ack("ack_w1", 8);
        send(16'h0002);
        wait_ack("ack_w2", 8);
        send(16'h0003);
        cyc(10);
        check("ack_held", 32'(ack), 32'(exp_ack));
        check("lvl_full", 32'(lvl), 32'd2);
        p0  = pops;
        rdy = 1'b1;
        wait_ack("ack_w3", 10);
        got = (pops - p0 >= 1) ? 1 : 0;
        check("pop_before_ack3", 32'(got), 32'd1);
        wait_drain("drain_bp");

        // Protocol error: extra toggle while holding a word.
        check("proto_clean", 32'(proto_err), 32'd0);
        rdy = 1'b0;
        send(16'h0010);
        wait_ack("ack_p1", 8);
        send(16'h0011);
        wait_ack("ack_p2", 8);
        send(16'h0012);
        cyc(6);
        req = ~req;
        cyc(8);
        check("proto_set", 32'(proto_err), 32'd1);
        check("lvl_proto", 32'(lvl), 32'd2);
        check("ack_proto_held", 32'(ack), 32'(exp_ack));
        p0  = pops;
        rdy = 1'b1;
        wait_ack("ack_p3", 10);
        wait_drain("drain_proto");
        cyc(4);
        check("word_count", 32'(pops - p0), 32'd3);
        check("proto_sticky", 32'(proto_err), 32'd1);

        // Asynchronous reset while holding with a full buffer.
        rdy = 1'b0;
        send(16'h0020);
        wait_ack("ack_r1", 8);
        send(16'h0021);
        wait_ack("ack_r2", 8);
        send(16'h0022);
        cyc(6);
        check("lvl_pre_rst", 32'(lvl), 32'd2);
        #1;
        rst_b = 1'b0;
        #1;
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_val", 32'(val), 32'd0);
        check("arst_lvl", 32'(lvl), 32'd0);
        check("arst_proto", 32'(proto_err), 32'd0);
        sb.delete();
        req     = 1'b0;
        exp_ack = 1'b0;
        cyc(3);
        rst_b = 1'b1;
        cyc(3);
        rdy = 1'b1;
        send(16'h5A5A);
        wait_ack("ack_after_rst", SYNC_STAGES + 3);
        wait_drain("drain_after_rst");

`ifdef REQ_ACK_RX_PARITY_EN
        check("par_clean", 32'(par_err), 32'd0);
        send(16'h0001, 1'b1);
        wait_ack("ack_badpar", 8);
        wait_drain("drain_badpar");
        check("par_set", 32'(par_err), 32'd1);
        send(16'h0003);
        wait_ack("ack_goodpar", 8);
        wait_drain("drain_goodpar");
        check("par_sticky", 32'(par_err), 32'd1);
`endif

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
